gemac_wb_init: RTL and testbench

Wishbone master that configures the simple GEMAC wrapper's control registers (misc settings, unicast/multicast filter addresses, MDIO divider) after reset and on request. After initialisation it forwards single runtime register writes from one user requester onto the same bus. It sits on the `wb_clk` domain and drives the wrapper's `wb_*` slave port directly. It replaces ad-hoc bring-up writes with a deterministic hardware sequence.

---
 rtl/gemac_wb_init.sv | 240 ++++++++++++++++++++++++
 tb/tb_gemac_wb_init.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemac_wb_init.sv
// gemac_wb_init
// -------------
// Wishbone master that programs the GEMAC wrapper's control registers after
// reset (and again on a 'start' pulse), then forwards single runtime register
// writes from one user requester onto the same bus.
//
// Init table, written in order (k = 0..5):
//   adr  0 : MISC_SETTINGS (zero-extended)
//   adr  4 : UCAST_ADDR[47:32]
//   adr  8 : UCAST_ADDR[31:0]
//   adr 12 : MCAST_ADDR[47:32]
//   adr 16 : MCAST_ADDR[31:0]
//   adr 20 : MDIO_DIV (nopre = 0)
//
// Ports:
//   wb_clk    in   clock
//   wb_rst_n  in   asynchronous active-low reset
//   start     in   one-cycle pulse, re-runs the init sequence (only in READY)
//   wb_adr    out  Wishbone address
//   wb_dat_o  out  Wishbone write data
//   wb_stb    out  Wishbone strobe
//   wb_cyc    out  Wishbone cycle
//   wb_we     out  Wishbone write enable
//   wb_ack    in   Wishbone acknowledge
//   usr_req   in   runtime write request (level, held until usr_ack)
//   usr_adr   in   runtime write address
//   usr_dat   in   runtime write data
//   usr_ack   out  one-cycle pulse when the user write has finished
//   busy      out  init sequence running (including the start delay)
//   done      out  init sequence completed
//   err       out  sticky: some bus cycle timed out
module gemac_wb_init #(
    parameter logic [5:0]  MISC_SETTINGS = 6'b111101,
    parameter logic [47:0] UCAST_ADDR    = 48'hA0B0_C0D0_A1B1,
    parameter logic [47:0] MCAST_ADDR    = 48'h0000_0000_0000,
    parameter logic [7:0]  MDIO_DIV      = 8'h08,
    parameter int          START_DLY     = 10,
    parameter int          TIMEOUT       = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        start,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat_o,
    output logic        wb_stb,
    output logic        wb_cyc,
    output logic        wb_we,
    input  logic        wb_ack,
    input  logic        usr_req,
    input  logic [7:0]  usr_adr,
    input  logic [31:0] usr_dat,
    output logic        usr_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int DLY_W = (START_DLY < 1) ? 1 : $clog2(START_DLY + 1);
    localparam int TO_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DLY);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT);
    localparam logic [2:0]       LAST_K   = 3'd5;

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_INIT_WR  = 3'd1,
        ST_INIT_GAP = 3'd2,
        ST_READY    = 3'd3,
        ST_USR_WR   = 3'd4,
        ST_USR_GAP  = 3'd5
    } state_t;

    // Register addresses are word aligned: entry k lives at byte address 4*k.
    function automatic logic [7:0] init_adr(input logic [2:0] k);
        init_adr = {3'b000, k, 2'b00};
    endfunction

    // Write data for init entry k.
    function automatic logic [31:0] init_dat(input logic [2:0] k);
        case (k)
            3'd0:    init_dat = {26'd0, MISC_SETTINGS};
            3'd1:    init_dat = {16'd0, UCAST_ADDR[47:32]};
            3'd2:    init_dat = UCAST_ADDR[31:0];
            3'd3:    init_dat = {16'd0, MCAST_ADDR[47:32]};
            3'd4:    init_dat = MCAST_ADDR[31:0];
            3'd5:    init_dat = {24'd0, MDIO_DIV};
            default: init_dat = 32'd0;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [2:0]       k_r, k_s;
    logic [DLY_W-1:0] dly_cnt_r, dly_cnt_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_s;
    logic [7:0]       adr_s;
    logic [31:0]      dat_s;
    logic             stb_s;
    logic             usr_ack_s;
    logic             busy_s;
    logic             done_s;
    logic             err_s;
    logic             cyc_end_s;

    // A bus cycle ends on ack, or is abandoned once the wait counter is exhausted.
    assign cyc_end_s = wb_ack || (to_cnt_r == TO_LAST);

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        dly_cnt_s = dly_cnt_r;
        to_cnt_s  = to_cnt_r;
        adr_s     = wb_adr;
        dat_s     = wb_dat_o;
        stb_s     = 1'b0;
        usr_ack_s = 1'b0;
        busy_s    = busy;
        done_s    = done;
        err_s     = err;

        case (state_r)
            ST_WAIT: begin
                if (dly_cnt_r == DLY_LAST) begin
                    state_s  = ST_INIT_WR;
                    k_s      = 3'd0;
                    adr_s    = init_adr(3'd0);
                    dat_s    = init_dat(3'd0);
                    to_cnt_s = {TO_W{1'b0}};
                    stb_s    = 1'b1;
                end else begin
                    dly_cnt_s = dly_cnt_r + DLY_W'(1);
                end
            end

            ST_INIT_WR: begin
                if (cyc_end_s) begin
                    state_s = ST_INIT_GAP;
                    // an ack on the very last allowed cycle still counts as success
                    err_s   = err | ~wb_ack;
                end else begin
                    stb_s    = 1'b1;
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end

            ST_INIT_GAP: begin
                if (k_r == LAST_K) begin
                    state_s = ST_READY;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s  = ST_INIT_WR;
                    k_s      = k_r + 3'd1;
                    adr_s    = init_adr(k_r + 3'd1);
                    dat_s    = init_dat(k_r + 3'd1);
                    to_cnt_s = {TO_W{1'b0}};
                    stb_s    = 1'b1;
                end
            end

            ST_READY: begin
                // start outranks a user request; the request stays pending
                if (start) begin
                    state_s   = ST_WAIT;
                    dly_cnt_s = {DLY_W{1'b0}};
                    done_s    = 1'b0;
                    err_s     = 1'b0;
                    busy_s    = 1'b1;
                end else if (usr_req) begin
                    // address/data are captured here, so later input changes are harmless
                    state_s  = ST_USR_WR;
                    adr_s    = usr_adr;
                    dat_s    = usr_dat;
                    to_cnt_s = {TO_W{1'b0}};
                    stb_s    = 1'b1;
                end else begin
                    state_s = ST_READY;
                end
            end

            ST_USR_WR: begin
                if (cyc_end_s) begin
                    state_s   = ST_USR_GAP;
                    err_s     = err | ~wb_ack;
                    usr_ack_s = 1'b1;
                end else begin
                    stb_s    = 1'b1;
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end

            ST_USR_GAP: begin
                state_s = ST_READY;
            end

            default: begin
                // unreachable encodings recover by re-running the whole init
                state_s   = ST_WAIT;
                dly_cnt_s = {DLY_W{1'b0}};
                k_s       = 3'd0;
                done_s    = 1'b0;
                busy_s    = 1'b1;
            end
        endcase
    end

    // State, counters and all outputs; reset drops the bus strobes immediately.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_r   <= ST_WAIT;
            k_r       <= 3'd0;
            dly_cnt_r <= {DLY_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            wb_adr    <= 8'd0;
            wb_dat_o  <= 32'd0;
            wb_stb    <= 1'b0;
            wb_cyc    <= 1'b0;
            wb_we     <= 1'b0;
            usr_ack   <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            dly_cnt_r <= dly_cnt_s;
            to_cnt_r  <= to_cnt_s;
            wb_adr    <= adr_s;
            wb_dat_o  <= dat_s;
            wb_stb    <= stb_s;
            wb_cyc    <= stb_s;
            wb_we     <= stb_s;
            usr_ack   <= usr_ack_s;
            busy      <= busy_s;
            done      <= done_s;
            err       <= err_s;
        end
    end

endmodule

// File: tb/tb_gemac_wb_init.sv
// tb_gemac_wb_init
// ----------------
// Bench for gemac_wb_init. A configurable Wishbone slave (ack latency, one
// address that never acks) answers the DUT. Expected bus writes are kept in
// an ordered list; a negedge compare process checks every bus cycle, its
// length and the usr_ack pulse against that list. Directed stimulus checks
// reset values, timing landmarks and status flags with literal values.
module tb_gemac_wb_init;

    localparam int TIMEOUT = 255;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic        start;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_o;
    logic        wb_stb, wb_cyc, wb_we, wb_ack;
    logic        usr_req;
    logic [7:0]  usr_adr;
    logic [31:0] usr_dat;
    logic        usr_ack, busy, done, err;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int stb_age = 0;
    int ack_lat = 0;
    int nak_adr = -1;

    logic [7:0]  exp_adr [64];
    logic [31:0] exp_dat [64];
    bit          exp_usr [64];
    int          wr_idx = 0;
    int          rd_idx = 0;
    bit          prev_stb = 1'b0;
    int          rise_edge = 0;

    gemac_wb_init dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .start    (start),
        .wb_adr   (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_we    (wb_we),
        .wb_ack   (wb_ack),
        .usr_req  (usr_req),
        .usr_adr  (usr_adr),
        .usr_dat  (usr_dat),
        .usr_ack  (usr_ack),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 wb_clk = ~wb_clk;

    always @(posedge wb_clk) edge_cnt <= edge_cnt + 1;

    // cycles the strobe has already been high before the current cycle
    always @(posedge wb_clk) stb_age <= wb_stb ? stb_age + 1 : 0;

    assign wb_ack = wb_stb && (stb_age >= ack_lat) && (int'(wb_adr) != nak_adr);

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d, input bit u);
        exp_adr[wr_idx] = a;
        exp_dat[wr_idx] = d;
        exp_usr[wr_idx] = u;
        wr_idx++;
    endtask

    task automatic push_init();
        push(8'd0,  32'h0000_003D, 1'b0);
        push(8'd4,  32'h0000_A0B0, 1'b0);
        push(8'd8,  32'hC0D0_A1B1, 1'b0);
        push(8'd12, 32'h0000_0000, 1'b0);
        push(8'd16, 32'h0000_0000, 1'b0);
        push(8'd20, 32'h0000_0008, 1'b0);
    endtask

    task automatic tick();
        @(negedge wb_clk);
        #1;
    endtask

    // which: 0 = wb_stb, 1 = done, 2 = usr_ack; e = edge number or -1 on expiry
    task automatic wait_sig(input int which, input int n, output int e);
        e = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if ((which == 0 && wb_stb) || (which == 1 && done) || (which == 2 && usr_ack)) begin
                e = edge_cnt;
                break;
            end
        end
    endtask

    // Compare process: bus contents, cycle length and usr_ack against the expected list.
    always @(negedge wb_clk) begin
        if (!wb_rst_n) begin
            prev_stb <= 1'b0;
            rd_idx   <= wr_idx;
        end else begin
            check1("usr_ack", usr_ack,
                   (prev_stb && !wb_stb && rd_idx < wr_idx) ? exp_usr[rd_idx] : 1'b0);
            check1("wb_cyc", wb_cyc, wb_stb);
            check1("wb_we", wb_we, wb_stb);
            if (wb_stb) begin
                if (rd_idx < wr_idx) begin
                    check32("wb_adr", 32'(wb_adr), 32'(exp_adr[rd_idx]));
                    check32("wb_dat_o", wb_dat_o, exp_dat[rd_idx]);
                    if (!prev_stb && exp_usr[rd_idx])
                        check1("done_before_usr", done, 1'b1);
                end else begin
                    check1("unexpected_cycle", wb_stb, 1'b0);
                end
                if (!prev_stb)
                    rise_edge <= edge_cnt;
            end else if (prev_stb && rd_idx < wr_idx) begin
                check32("stb_len", edge_cnt - rise_edge,
                        (int'(exp_adr[rd_idx]) == nak_adr) ? TIMEOUT + 1 : ack_lat + 1);
                rd_idx <= rd_idx + 1;
            end
            prev_stb <= wb_stb;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e0, e1;
        bit  found;
        wb_rst_n = 1'b0;
        start    = 1'b0;
        usr_req  = 1'b0;
        usr_adr  = 8'd0;
        usr_dat  = 32'd0;
        repeat (2) tick();

        // reset values
        check1("rst_stb", wb_stb, 1'b0);
        check1("rst_cyc", wb_cyc, 1'b0);
        check1("rst_we", wb_we, 1'b0);
        check1("rst_usr_ack", usr_ack, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_busy", busy, 1'b1);
        check32("rst_adr", 32'(wb_adr), 32'd0);
        check32("rst_dat", wb_dat_o, 32'd0);

        // init after reset, immediate ack: timing landmarks
        ack_lat  = 0;
        nak_adr  = -1;
        wb_rst_n = 1'b1;
        e0 = edge_cnt;
        push_init();
        wait_sig(0, 30, e1);
        check32("first_stb_edge", e1 - e0, 32'd11);
        wait_sig(1, 100, e1);
        check32("done_edge", e1 - e0, 32'd23);
        check1("a_done", done, 1'b1);
        check1("a_busy", busy, 1'b0);
        check1("a_err", err, 1'b0);
        check32("a_writes", rd_idx, wr_idx);

        // user write in READY, slave acks after one cycle; data changes after acceptance
        ack_lat = 1;
        push(8'h40, 32'hDEAD_BEEF, 1'b1);
        usr_adr = 8'h40;
        usr_dat = 32'hDEAD_BEEF;
        usr_req = 1'b1;
        e0 = edge_cnt;
        wait_sig(0, 10, e1);
        check32("usr_stb_latency", e1 - e0, 32'd1);
        usr_adr = 8'hFF;
        usr_dat = 32'hFFFF_FFFF;
        wait_sig(2, 10, e1);
        check1("b_usr_ack_seen", e1 >= 0, 1'b1);
        usr_req = 1'b0;
        repeat (4) tick();
        check32("b_writes", rd_idx, wr_idx);
        check1("b_done", done, 1'b1);

        // re-run with a slave that never acks adr 12
        nak_adr = 12;
        push_init();
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("c1_done_cleared", done, 1'b0);
        check1("c1_busy", busy, 1'b1);
        wait_sig(1, 800, e1);
        check1("c1_done_seen", e1 >= 0, 1'b1);
        check1("c1_err", err, 1'b1);
        check32("c1_writes", rd_idx, wr_idx);

        // start and usr_req together: init first, then the held user write
        nak_adr = -1;
        ack_lat = 0;
        push_init();
        push(8'h18, 32'h0000_1234, 1'b1);
        start   = 1'b1;
        usr_req = 1'b1;
        usr_adr = 8'h18;
        usr_dat = 32'h0000_1234;
        tick();
        start = 1'b0;
        check1("c2_err_cleared", err, 1'b0);
        check1("c2_done_cleared", done, 1'b0);
        check1("c2_busy", busy, 1'b1);
        wait_sig(2, 200, e1);
        check1("c2_usr_ack_seen", e1 >= 0, 1'b1);
        usr_req = 1'b0;
        repeat (4) tick();
        check32("c2_writes", rd_idx, wr_idx);
        check1("c2_done", done, 1'b1);
        check1("c2_err", err, 1'b0);

        // reset during the adr 8 write, slow slave
        ack_lat = 5;
        push_init();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wb_stb && wb_adr == 8'd8) begin
                found = 1'b1;
                break;
            end
        end
        check1("d_adr8_found", found, 1'b1);
        @(posedge wb_clk);
        #2;
        check1("d_stb_before_rst", wb_stb, 1'b1);
        wb_rst_n = 1'b0;
        #1;
        check1("d_async_stb", wb_stb, 1'b0);
        check1("d_async_cyc", wb_cyc, 1'b0);
        check1("d_async_we", wb_we, 1'b0);
        repeat (2) tick();
        check1("d_rst_busy", busy, 1'b1);
        check1("d_rst_done", done, 1'b0);
        check32("d_rst_adr", 32'(wb_adr), 32'd0);
        wb_rst_n = 1'b1;
        e0 = edge_cnt;
        push_init();
        wait_sig(0, 30, e1);
        check32("d_restart_edge", e1 - e0, 32'd11);
        check32("d_restart_adr", 32'(wb_adr), 32'd0);
        wait_sig(1, 200, e1);
        check1("d_done_seen", e1 >= 0, 1'b1);
        check32("d_writes", rd_idx, wr_idx);
        check1("d_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
